neopixel_rx: RTL and testbench

NEOPIXEL_RX -- requirements
Module: neopixel_rx

---
 rtl/neopixel_rx.sv | 200 ++++++++++++++++++++
 tb/tb_neopixel_rx.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/neopixel_rx.sv
//==============================================================================
// Module      : neopixel_rx
// Description : WS2812-style serial receiver; decodes pulse widths into bytes
//               and writes them to a LEDS*3 byte buffer.
//               Optional: NEOPIXEL_RX_GLITCH_FILTER_EN ignores short high pulses.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module neopixel_rx #(
    parameter int LEDS   = 30,
    parameter int CLK_HZ = 50_000_000
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_din,
    output logic                           o_wr_en,
    output logic [$clog2(LEDS*3)-1:0]      o_wr_addr,
    output logic [7:0]                     o_wr_data,
    output logic                           o_busy,
    output logic                           o_frame_done,
    output logic [$clog2(LEDS*3+1)-1:0]    o_frame_len,
    output logic                           o_overflow,
    output logic                           o_err_partial
);

    localparam int c_NBYTES  = LEDS * 3;
    localparam int c_AW      = $clog2(c_NBYTES);
    localparam int c_LW      = $clog2(c_NBYTES + 1);
    localparam int c_TH_CYC  = int'((longint'(CLK_HZ) * 6) / 10_000_000);
    localparam int c_RST_CYC = CLK_HZ / 20_000;
    localparam int c_GL_CYC  = int'((longint'(CLK_HZ) * 15) / 100_000_000);
    localparam int c_CW      = $clog2(c_RST_CYC + 1);

    localparam logic [c_CW-1:0] c_TH    = c_CW'(c_TH_CYC);
    localparam logic [c_CW-1:0] c_RST   = c_CW'(c_RST_CYC);
    localparam logic [c_CW-1:0] c_RSTM1 = c_CW'(c_RST_CYC - 1);
    localparam logic [c_CW-1:0] c_GL    = c_CW'(c_GL_CYC);
    localparam logic [c_LW-1:0] c_NB    = c_LW'(c_NBYTES);

`ifdef NEOPIXEL_RX_GLITCH_FILTER_EN
    localparam bit c_GLITCH_EN = 1'b1;
`else
    localparam bit c_GLITCH_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_WAIT_IDLE = 2'd0,
        S_IDLE      = 2'd1,
        S_HIGH      = 2'd2,
        S_LOW       = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [1:0]        r_sync;
    logic              w_din;
    logic [c_CW-1:0]   r_hcnt;
    logic [c_CW-1:0]   r_lcnt;
    logic [7:0]        r_shift;
    logic [2:0]        r_bitcnt;
    logic [c_LW-1:0]   r_byte_idx;
    logic              r_in_frame;
    logic              w_bit_evt;
    logic              w_frame_end;
    logic              w_bit;
    logic [7:0]        w_byte;

    assign w_din  = r_sync[1];
    assign w_bit  = (r_hcnt >= c_TH);
    assign w_byte = {r_shift[6:0], w_bit};
    assign o_busy = (r_state == S_HIGH) || (r_state == S_LOW);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_WAIT_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_bit_evt   = 1'b0;
        w_frame_end = 1'b0;
        case (r_state)
            S_WAIT_IDLE: begin
                if (!w_din && (r_lcnt >= c_RSTM1)) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_IDLE: begin
                if (w_din) begin
                    w_state_nxt = S_HIGH;
                end
            end
            S_HIGH: begin
                if (!w_din) begin
                    // A filtered glitch returns to wherever it came from.
                    if (c_GLITCH_EN && (r_hcnt < c_GL)) begin
                        w_state_nxt = r_in_frame ? S_LOW : S_IDLE;
                    end else begin
                        w_bit_evt   = 1'b1;
                        w_state_nxt = S_LOW;
                    end
                end
            end
            S_LOW: begin
                if (w_din) begin
                    w_state_nxt = S_HIGH;
                end else if (r_lcnt >= c_RSTM1) begin
                    w_frame_end = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_WAIT_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync        <= '0;
            r_hcnt        <= '0;
            r_lcnt        <= '0;
            r_shift       <= '0;
            r_bitcnt      <= '0;
            r_byte_idx    <= '0;
            r_in_frame    <= 1'b0;
            o_wr_en       <= 1'b0;
            o_wr_addr     <= '0;
            o_wr_data     <= '0;
            o_frame_done  <= 1'b0;
            o_frame_len   <= '0;
            o_overflow    <= 1'b0;
            o_err_partial <= 1'b0;
        end else begin
            r_sync       <= {r_sync[0], i_din};
            o_wr_en      <= 1'b0;
            o_frame_done <= 1'b0;
            case (r_state)
                S_WAIT_IDLE: begin
                    if (w_din || (w_state_nxt == S_IDLE)) begin
                        r_lcnt <= '0;
                    end else begin
                        r_lcnt <= r_lcnt + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (w_din) begin
                        r_hcnt <= c_CW'(1);
                    end
                end
                S_HIGH: begin
                    if (w_din) begin
                        if (r_hcnt != c_RST) begin
                            r_hcnt <= r_hcnt + 1'b1;
                        end
                    end else if (w_bit_evt) begin
                        r_lcnt     <= c_CW'(1);
                        r_shift    <= w_byte;
                        r_bitcnt   <= r_bitcnt + 3'd1;
                        r_in_frame <= 1'b1;
                        if (r_bitcnt == 3'd7) begin
                            if (r_byte_idx < c_NB) begin
                                o_wr_en    <= 1'b1;
                                o_wr_addr  <= r_byte_idx[c_AW-1:0];
                                o_wr_data  <= w_byte;
                                r_byte_idx <= r_byte_idx + 1'b1;
                            end else begin
                                o_overflow <= 1'b1;
                            end
                        end
                    end
                end
                S_LOW: begin
                    if (w_din) begin
                        r_hcnt <= c_CW'(1);
                    end else if (w_frame_end) begin
                        o_frame_done <= 1'b1;
                        o_frame_len  <= r_byte_idx;
                        if (r_bitcnt != 3'd0) begin
                            o_err_partial <= 1'b1;
                        end
                        r_bitcnt   <= '0;
                        r_shift    <= '0;
                        r_byte_idx <= '0;
                        r_in_frame <= 1'b0;
                        r_lcnt     <= '0;
                    end else begin
                        r_lcnt <= r_lcnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_neopixel_rx.sv
//==============================================================================
// Module      : tb_neopixel_rx
// Description : Randomized self-checking bench for neopixel_rx with a
//               bit-list reference model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_neopixel_rx;

    localparam int LEDS      = 30;
    localparam int CLK_HZ    = 50_000_000;
    localparam int c_NB      = LEDS * 3;
    localparam int c_AW      = $clog2(c_NB);
    localparam int c_LW      = $clog2(c_NB + 1);
    localparam int c_RST_CYC = CLK_HZ / 20_000;

    logic              clk = 1'b0;
    logic              rst;
    logic              din;
    logic              wr_en;
    logic [c_AW-1:0]   wr_addr;
    logic [7:0]        wr_data;
    logic              busy;
    logic              frame_done;
    logic [c_LW-1:0]   frame_len;
    logic              overflow;
    logic              err_partial;

    always #5 clk = ~clk;

    neopixel_rx #(.LEDS(LEDS), .CLK_HZ(CLK_HZ)) u_dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_din         (din),
        .o_wr_en       (wr_en),
        .o_wr_addr     (wr_addr),
        .o_wr_data     (wr_data),
        .o_busy        (busy),
        .o_frame_done  (frame_done),
        .o_frame_len   (frame_len),
        .o_overflow    (overflow),
        .o_err_partial (err_partial)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int q_wa[$];
    int q_wd[$];
    int q_len[$];
    int q_hi[$];
    int q_lo[$];
    bit q_exp[$];
    bit exp_ovf  = 1'b0;
    bit exp_perr = 1'b0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (wr_en) begin
            q_wa.push_back(int'(wr_addr));
            q_wd.push_back(int'(wr_data));
        end
        if (frame_done) begin
            q_len.push_back(int'(frame_len));
        end
    end

    // Fast timing keeps the long frames short; normal timing is WS2812-like.
    task automatic add_bit(input bit b, input bit fast);
        int hi;
        int lo;
        if (fast) begin
            hi = b ? int'($urandom_range(34, 31)) : int'($urandom_range(12, 8));
            lo = int'($urandom_range(5, 2));
        end else begin
            hi = b ? int'($urandom_range(45, 34)) : int'($urandom_range(24, 12));
            lo = int'($urandom_range(40, 15));
        end
        q_hi.push_back(hi);
        q_lo.push_back(lo);
        q_exp.push_back(b);
    endtask

    task automatic add_byte(input logic [7:0] v, input bit fast);
        for (int i = 7; i >= 0; i--) begin
            add_bit(v[i], fast);
        end
    endtask

    task automatic add_glitch();
        q_lo[q_lo.size()-1] = 10;
        q_hi.push_back(3);
        q_lo.push_back(10);
`ifndef NEOPIXEL_RX_GLITCH_FILTER_EN
        q_exp.push_back(1'b0);
`endif
    endtask

    task automatic send_pulses();
        for (int i = 0; i < q_hi.size(); i++) begin
            din = 1'b1;
            repeat (q_hi[i]) @(negedge clk);
            din = 1'b0;
            repeat (q_lo[i]) @(negedge clk);
        end
        q_hi.delete();
        q_lo.delete();
    endtask

    task automatic check_frame();
        int nbits;
        int nbytes;
        int nexp;
        int bv;
        nbits  = q_exp.size();
        nbytes = nbits / 8;
        nexp   = (nbytes < c_NB) ? nbytes : c_NB;
        check_eq("wr_count", q_wa.size(), nexp);
        for (int i = 0; i < nexp && i < q_wa.size(); i++) begin
            bv = 0;
            for (int j = 0; j < 8; j++) begin
                bv = (bv << 1) | int'(q_exp[8*i+j]);
            end
            check_eq("wr_addr", q_wa[i], i);
            check_eq("wr_data", q_wd[i], bv);
        end
        check_eq("done_count", q_len.size(), (nbits > 0) ? 1 : 0);
        if (q_len.size() > 0) begin
            check_eq("frame_len", q_len[0], nexp);
        end
        if (nbytes > c_NB) exp_ovf = 1'b1;
        if ((nbits % 8) != 0) exp_perr = 1'b1;
        check_eq("overflow", int'(overflow), int'(exp_ovf));
        check_eq("err_partial", int'(err_partial), int'(exp_perr));
        check_eq("busy_after_frame", int'(busy), 0);
        q_wa.delete();
        q_wd.delete();
        q_len.delete();
        q_exp.delete();
    endtask

    task automatic run_frame();
        send_pulses();
        din = 1'b0;
        repeat (c_RST_CYC + 30) @(negedge clk);
        check_frame();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_wr_en"}, int'(wr_en), 0);
        check_eq({tag, "_wr_addr"}, int'(wr_addr), 0);
        check_eq({tag, "_wr_data"}, int'(wr_data), 0);
        check_eq({tag, "_busy"}, int'(busy), 0);
        check_eq({tag, "_frame_done"}, int'(frame_done), 0);
        check_eq({tag, "_frame_len"}, int'(frame_len), 0);
        check_eq({tag, "_overflow"}, int'(overflow), 0);
        check_eq({tag, "_err_partial"}, int'(err_partial), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] v;
        logic [7:0] a5;
        int         k;
        int         nb;
        int         nx;

        rst = 1'b1;
        din = 1'b0;
        repeat (4) @(negedge clk);
        check_reset_outputs("rst0");
        rst = 1'b0;
        repeat (c_RST_CYC + 30) @(negedge clk);

        // 0xA5 with nominal WS2812 timings
        a5 = 8'hA5;
        for (int i = 7; i >= 0; i--) begin
            q_hi.push_back(a5[i] ? 40 : 20);
            q_lo.push_back(a5[i] ? 22 : 42);
            q_exp.push_back(a5[i]);
        end
        run_frame();

        // Full frame, byte n = n
        for (int n = 0; n < c_NB; n++) begin
            add_byte(8'(n), 1'b1);
        end
        run_frame();

        // One byte too many
        for (int n = 0; n <= c_NB; n++) begin
            add_byte(8'($urandom), 1'b1);
        end
        run_frame();

        // 12 bits: one byte plus a pending nibble
        for (int i = 0; i < 12; i++) begin
            add_bit(1'($urandom), 1'b0);
        end
        run_frame();

        // Short high pulse in the low phase of a bit
        v = 8'($urandom);
        k = int'($urandom_range(6, 0));
        for (int i = 0; i < 8; i++) begin
            add_bit(v[7-i], 1'b0);
            if (i == k) add_glitch();
        end
        run_frame();

        // Random short frames with random trailing bits
        for (int f = 0; f < 3; f++) begin
            nb = int'($urandom_range(4, 1));
            nx = int'($urandom_range(7, 0));
            for (int n = 0; n < nb; n++) begin
                add_byte(8'($urandom), 1'b0);
            end
            for (int i = 0; i < nx; i++) begin
                add_bit(1'($urandom), 1'b0);
            end
            run_frame();
        end

        // Reset in the middle of a byte
        for (int i = 0; i < 4; i++) begin
            add_bit(1'($urandom), 1'b0);
        end
        send_pulses();
        check_eq("busy_mid_frame", int'(busy), 1);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst_mid");
        rst = 1'b0;
        q_exp.delete();
        exp_ovf  = 1'b0;
        exp_perr = 1'b0;
        repeat (c_RST_CYC + 30) @(negedge clk);
        check_eq("wr_after_rst", q_wa.size(), 0);
        check_eq("done_after_rst", q_len.size(), 0);
        q_wa.delete();
        q_wd.delete();
        q_len.delete();
        add_byte(8'($urandom), 1'b0);
        run_frame();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
